// File: rtl/local_network_interface_pkg.sv
// Shared configuration and packet format for the local network interface.
package local_network_interface_pkg;

    localparam int unsigned NET_X  = 4;
    localparam int unsigned NET_Y  = 4;
    localparam int unsigned X_W    = $clog2(NET_X);
    localparam int unsigned Y_W    = $clog2(NET_Y);
    localparam int unsigned TS_W   = 16;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [X_W-1:0]    dest_x;
        logic [Y_W-1:0]    dest_y;
        logic [X_W-1:0]    src_x;
        logic [Y_W-1:0]    src_y;
        logic [TS_W-1:0]   timestamp;
        logic [DATA_W-1:0] data;
    } packet_t;

    // Unsigned 32-bit add that clamps at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [TS_W-1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + 33'(b);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/ni_packet_fifo.sv
// Packet FIFO with occupancy count; pushes while full and pops while empty are ignored.
module ni_packet_fifo
    import local_network_interface_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  packet_t                    din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output packet_t                    head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    packet_t        mem [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [CW-1:0]  cnt_q;
    logic           push_acc, pop_acc;

    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign head     = mem[rd_q];
    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

    // Storage array: no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_q] <= din;
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_acc) wr_q <= wr_q + AW'(1);
            if (pop_acc)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_acc) - CW'(pop_acc);
        end
    end

endmodule

// File: rtl/local_network_interface.sv
// PE-side network interface on a router local port: injection/ejection queues and statistics.
module local_network_interface
    import local_network_interface_pkg::*;
#(
    parameter int unsigned X_LOC     = 0,
    parameter int unsigned Y_LOC     = 0,
    parameter int unsigned INJ_DEPTH = 4,
    parameter int unsigned EJ_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pe_req_val,
    input  logic [X_W-1:0]    i_pe_dest_x,
    input  logic [Y_W-1:0]    i_pe_dest_y,
    input  logic [DATA_W-1:0] i_pe_payload,
    output logic              o_pe_req_rdy,
    output packet_t           o_data,
    output logic              o_data_val,
    input  logic              i_en,
    input  packet_t           i_data,
    input  logic              i_data_val,
    output logic              o_en,
    output logic              o_pe_rx_val,
    output packet_t           o_pe_rx_packet,
    input  logic              i_pe_rx_rdy,
    output logic [31:0]       o_sent_count,
    output logic [31:0]       o_recv_count,
    output logic [31:0]       o_latency_sum,
    output logic [TS_W-1:0]   o_latency_max,
    output logic              o_err_misroute,
    output logic              o_err_overflow
);

    localparam int unsigned INJ_CW = $clog2(INJ_DEPTH + 1);
    localparam int unsigned EJ_CW  = $clog2(EJ_DEPTH + 1);

    logic [TS_W-1:0]   cyc_q;
    packet_t           inj_pkt;
    logic              inj_push, inj_full, inj_empty;
    logic [INJ_CW-1:0] inj_count;
    logic              ej_push, ej_pop, ej_full, ej_empty;
    logic [EJ_CW-1:0]  ej_count, ej_count_next;
    logic              en_d;
    logic [TS_W-1:0]   lat;
    logic              misrouted;
    logic              unused_inj_full;

    assign unused_inj_full = inj_full;

    // Injection: stamp source coordinates and the current cycle into the packet.
    assign o_pe_req_rdy = (inj_count < INJ_CW'(INJ_DEPTH));
    assign inj_push     = i_pe_req_val & o_pe_req_rdy;
    assign o_data_val   = ~inj_empty & i_en;

    always_comb begin
        inj_pkt           = '0;
        inj_pkt.dest_x    = i_pe_dest_x;
        inj_pkt.dest_y    = i_pe_dest_y;
        inj_pkt.src_x     = X_W'(X_LOC);
        inj_pkt.src_y     = Y_W'(Y_LOC);
        inj_pkt.timestamp = cyc_q;
        inj_pkt.data      = i_pe_payload;
    end

    ni_packet_fifo #(.DEPTH(INJ_DEPTH)) u_inj_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inj_push),
        .pop   (o_data_val),
        .din   (inj_pkt),
        .full  (inj_full),
        .empty (inj_empty),
        .count (inj_count),
        .head  (o_data)
    );

    // Ejection: a packet arriving while full is dropped, not queued.
    assign ej_push     = i_data_val & ~ej_full;
    assign ej_pop      = ~ej_empty & i_pe_rx_rdy;
    assign o_pe_rx_val = ~ej_empty;

    ni_packet_fifo #(.DEPTH(EJ_DEPTH)) u_ej_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (i_data_val),
        .pop   (i_pe_rx_rdy),
        .din   (i_data),
        .full  (ej_full),
        .empty (ej_empty),
        .count (ej_count),
        .head  (o_pe_rx_packet)
    );

    // Router enable reflects room in the ejection queue after this edge's traffic.
    always_comb begin
        ej_count_next = ej_count + EJ_CW'(ej_push) - EJ_CW'(ej_pop);
        en_d          = (ej_count_next < EJ_CW'(EJ_DEPTH));
    end

    assign lat       = cyc_q - i_data.timestamp;
    assign misrouted = (i_data.dest_x != X_W'(X_LOC)) || (i_data.dest_y != Y_W'(Y_LOC));

    // Cycle counter, flow-control register, statistics and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q          <= '0;
            o_en           <= 1'b0;
            o_sent_count   <= '0;
            o_recv_count   <= '0;
            o_latency_sum  <= '0;
            o_latency_max  <= '0;
            o_err_misroute <= 1'b0;
            o_err_overflow <= 1'b0;
        end else begin
            cyc_q <= cyc_q + TS_W'(1);
            o_en  <= en_d;
            if (o_data_val) o_sent_count <= o_sent_count + 32'd1;
            if (i_data_val && ej_full) o_err_overflow <= 1'b1;
            if (ej_push) begin
                o_recv_count  <= o_recv_count + 32'd1;
                o_latency_sum <= sat_add32(o_latency_sum, lat);
                if (lat > o_latency_max) o_latency_max <= lat;
                if (misrouted) o_err_misroute <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_local_network_interface.sv
// Directed self-checking bench for local_network_interface (node at X=1, Y=2).
module tb_local_network_interface;
    import local_network_interface_pkg::*;

    localparam int unsigned XL = 1;
    localparam int unsigned YL = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_pe_req_val;
    logic [X_W-1:0]    i_pe_dest_x;
    logic [Y_W-1:0]    i_pe_dest_y;
    logic [DATA_W-1:0] i_pe_payload;
    logic              o_pe_req_rdy;
    packet_t           o_data;
    logic              o_data_val;
    logic              i_en;
    packet_t           i_data;
    logic              i_data_val;
    logic              o_en;
    logic              o_pe_rx_val;
    packet_t           o_pe_rx_packet;
    logic              i_pe_rx_rdy;
    logic [31:0]       o_sent_count, o_recv_count, o_latency_sum;
    logic [TS_W-1:0]   o_latency_max;
    logic              o_err_misroute, o_err_overflow;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    logic [15:0] cm;

    local_network_interface #(
        .X_LOC(XL), .Y_LOC(YL), .INJ_DEPTH(4), .EJ_DEPTH(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_pe_req_val   (i_pe_req_val),
        .i_pe_dest_x    (i_pe_dest_x),
        .i_pe_dest_y    (i_pe_dest_y),
        .i_pe_payload   (i_pe_payload),
        .o_pe_req_rdy   (o_pe_req_rdy),
        .o_data         (o_data),
        .o_data_val     (o_data_val),
        .i_en           (i_en),
        .i_data         (i_data),
        .i_data_val     (i_data_val),
        .o_en           (o_en),
        .o_pe_rx_val    (o_pe_rx_val),
        .o_pe_rx_packet (o_pe_rx_packet),
        .i_pe_rx_rdy    (i_pe_rx_rdy),
        .o_sent_count   (o_sent_count),
        .o_recv_count   (o_recv_count),
        .o_latency_sum  (o_latency_sum),
        .o_latency_max  (o_latency_max),
        .o_err_misroute (o_err_misroute),
        .o_err_overflow (o_err_overflow)
    );

    always #5 clk = ~clk;

    // Reference cycle count: same definition as the interface's timestamp clock.
    always @(posedge clk or posedge reset) begin
        if (reset) cm <= '0;
        else       cm <= cm + 16'd1;
    end

    typedef struct {
        logic [X_W-1:0] dx;
        logic [Y_W-1:0] dy;
        logic [15:0]    lat;
        logic [31:0]    data;
        logic [31:0]    e_recv;
        logic [31:0]    e_sum;
        logic [15:0]    e_max;
    } ej_vec_t;

    ej_vec_t tbl [4];

    function automatic packet_t mk_pkt(input logic [X_W-1:0] dx, input logic [Y_W-1:0] dy,
                                       input logic [X_W-1:0] sx, input logic [Y_W-1:0] sy,
                                       input logic [15:0] ts, input logic [31:0] d);
        packet_t p;
        p.dest_x = dx; p.dest_y = dy; p.src_x = sx; p.src_y = sy;
        p.timestamp = ts; p.data = d;
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cm(input logic [15:0] v);
        for (int i = 0; i < 200 && cm != v; i++) step();
    endtask

    task automatic eject(input logic [X_W-1:0] dx, input logic [Y_W-1:0] dy,
                         input logic [15:0] lat, input logic [31:0] d);
        i_data_val = 1'b1;
        i_data     = mk_pkt(dx, dy, 2'd0, 2'd0, cm - lat, d);
        step();
        i_data_val = 1'b0;
        @(negedge clk);
    endtask

    logic [15:0] ts_rec [4];
    packet_t     exp_pkt;

    initial begin
        tbl[0] = '{dx: 2'(XL), dy: 2'(YL), lat: 16'd20,  data: 32'h4000_0000,
                   e_recv: 32'd2, e_sum: 32'd52,  e_max: 16'd32};
        tbl[1] = '{dx: 2'(XL), dy: 2'(YL), lat: 16'd100, data: 32'h4000_0001,
                   e_recv: 32'd3, e_sum: 32'd152, e_max: 16'd100};
        tbl[2] = '{dx: 2'(XL), dy: 2'(YL), lat: 16'd0,   data: 32'h4000_0002,
                   e_recv: 32'd4, e_sum: 32'd152, e_max: 16'd100};
        tbl[3] = '{dx: 2'(XL), dy: 2'(YL), lat: 16'd7,   data: 32'h4000_0003,
                   e_recv: 32'd5, e_sum: 32'd159, e_max: 16'd100};

        reset = 1'b1; i_pe_req_val = 1'b0; i_pe_dest_x = '0; i_pe_dest_y = '0;
        i_pe_payload = '0; i_en = 1'b0; i_data = '0; i_data_val = 1'b0; i_pe_rx_rdy = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_o_en", o_en, 0);
        chk("rst_data_val", o_data_val, 0);
        chk("rst_rx_val", o_pe_rx_val, 0);
        chk("rst_sent", o_sent_count, 0);
        chk("rst_recv", o_recv_count, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("o_en_before_first_edge", o_en, 0);
        step();
        @(negedge clk);
        chk("o_en_after_first_edge", o_en, 1);
        chk("idle_req_rdy", o_pe_req_rdy, 1);
        chk("idle_lat_sum", o_latency_sum, 0);
        chk("idle_lat_max", o_latency_max, 0);
        chk("idle_errs", {o_err_misroute, o_err_overflow}, 0);

        // Single injection at cyc 5
        step();
        wait_cm(16'd5);
        i_pe_req_val = 1'b1; i_pe_dest_x = 2'd2; i_pe_dest_y = 2'd1;
        i_pe_payload = 32'hA5A5_0001; i_en = 1'b1;
        @(negedge clk);
        chk("inj_req_rdy", o_pe_req_rdy, 1);
        chk("inj_no_bypass", o_data_val, 0);
        step();
        i_pe_req_val = 1'b0;
        @(negedge clk);
        chk("inj_data_val", o_data_val, 1);
        chk("inj_packet", o_data, mk_pkt(2'd2, 2'd1, 2'(XL), 2'(YL), 16'd5, 32'hA5A5_0001));
        step();
        @(negedge clk);
        chk("inj_sent", o_sent_count, 1);
        chk("inj_drained", o_data_val, 0);

        // Ejection with timestamp wrap: ts 0xFFF0 at cyc 0x0010 -> latency 0x20
        step();
        wait_cm(16'h0010);
        exp_pkt = mk_pkt(2'(XL), 2'(YL), 2'd3, 2'd0, 16'hFFF0, 32'hBEEF_0000);
        i_data = exp_pkt; i_data_val = 1'b1;
        step();
        i_data_val = 1'b0;
        @(negedge clk);
        chk("wrap_recv", o_recv_count, 1);
        chk("wrap_sum", o_latency_sum, 32'h20);
        chk("wrap_max", o_latency_max, 16'h20);
        chk("wrap_rx_val", o_pe_rx_val, 1);
        chk("wrap_rx_pkt", o_pe_rx_packet, exp_pkt);
        i_pe_rx_rdy = 1'b1;
        step();
        i_pe_rx_rdy = 1'b0;
        @(negedge clk);
        chk("wrap_rx_consumed", o_pe_rx_val, 0);

        // Injection queue fills with the router stalled, then drains in order
        step();
        i_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_pe_req_val = 1'b1; i_pe_dest_x = 2'(k); i_pe_dest_y = 2'(3 - (k % 4));
            i_pe_payload = 32'h100 + 32'(k);
            @(negedge clk);
            chk($sformatf("fill_rdy_%0d", k), o_pe_req_rdy, (k < 4) ? 1 : 0);
            chk($sformatf("fill_stalled_%0d", k), o_data_val, 0);
            if (k < 4) ts_rec[k] = cm;
            step();
        end
        i_pe_req_val = 1'b0; i_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("drain_val_%0d", k), o_data_val, 1);
            chk($sformatf("drain_pkt_%0d", k), o_data,
                mk_pkt(2'(k), 2'(3 - k), 2'(XL), 2'(YL), ts_rec[k], 32'h100 + 32'(k)));
            step();
        end
        @(negedge clk);
        chk("drain_empty", o_data_val, 0);
        chk("drain_sent", o_sent_count, 5);

        // Ejection statistics table
        i_pe_rx_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            eject(tbl[k].dx, tbl[k].dy, tbl[k].lat, tbl[k].data);
            chk($sformatf("tbl_recv_%0d", k), o_recv_count, tbl[k].e_recv);
            chk($sformatf("tbl_sum_%0d", k), o_latency_sum, tbl[k].e_sum);
            chk($sformatf("tbl_max_%0d", k), o_latency_max, tbl[k].e_max);
            chk($sformatf("tbl_rx_data_%0d", k), o_pe_rx_packet.data, tbl[k].data);
            chk($sformatf("tbl_misroute_%0d", k), o_err_misroute, 0);
        end

        // Ejection overflow: PE stalled, four fill the queue, fifth is dropped
        step();
        i_pe_rx_rdy = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            eject(2'(XL), 2'(YL), 16'd1, 32'h300 + 32'(k));
            chk($sformatf("ovf_o_en_%0d", k), o_en, (k < 3) ? 1 : 0);
            step();
        end
        chk("ovf_pre_flag", o_err_overflow, 0);
        eject(2'(XL), 2'(YL), 16'd200, 32'h3FF);
        chk("ovf_flag", o_err_overflow, 1);
        chk("ovf_recv", o_recv_count, 9);
        chk("ovf_sum", o_latency_sum, 163);
        chk("ovf_max", o_latency_max, 100);
        i_pe_rx_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_drain_val_%0d", k), o_pe_rx_val, 1);
            chk($sformatf("ovf_drain_data_%0d", k), o_pe_rx_packet.data, 32'h300 + 32'(k));
            step();
            @(negedge clk);
        end
        chk("ovf_drain_empty", o_pe_rx_val, 0);
        chk("ovf_o_en_back", o_en, 1);

        // Misrouted packet is flagged but still delivered; flag is sticky
        i_pe_rx_rdy = 1'b0;
        step();
        eject(2'd3, 2'd3, 16'd5, 32'h5000_0000);
        chk("mis_flag", o_err_misroute, 1);
        chk("mis_rx_val", o_pe_rx_val, 1);
        chk("mis_rx_dest", {o_pe_rx_packet.dest_x, o_pe_rx_packet.dest_y}, 4'hF);
        chk("mis_recv", o_recv_count, 10);
        chk("mis_sum", o_latency_sum, 168);
        i_pe_rx_rdy = 1'b1;
        repeat (100) step();
        @(negedge clk);
        chk("mis_sticky", o_err_misroute, 1);
        chk("ovf_sticky", o_err_overflow, 1);
        chk("mis_consumed", o_pe_rx_val, 0);
        chk("final_sent", o_sent_count, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
